// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the write-back/commit stage: bundle layouts, exception
// vector bit positions, exception codes and the commit FSM encoding.
package wb_commit_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned CSR_NUM_W = 14;
    localparam int unsigned EXC_W     = 15;
    localparam int unsigned ECODE_W   = 6;
    localparam int unsigned ESUB_W    = 9;
    localparam int unsigned TLB_OP_W  = 4;
    localparam int unsigned ZIP_W     = 187;
    localparam int unsigned EXC_BUS_W = EXC_W + XLEN;

    // MEM->WB bundle, MSB first: {valid,pc,IR,gr_we,rf_waddr,rf_wdata,
    // tlbrd,tlbwr,tlbfill,invtlb,csr_re,csr_we,csr_wmask,csr_wvalue,csr_num}
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      ir;
        logic                 gr_we;
        logic [REG_AW-1:0]    rf_waddr;
        logic [XLEN-1:0]      rf_wdata;
        logic                 tlbrd;
        logic                 tlbwr;
        logic                 tlbfill;
        logic                 invtlb;
        logic                 csr_re;
        logic                 csr_we;
        logic [XLEN-1:0]      csr_wmask;
        logic [XLEN-1:0]      csr_wvalue;
        logic [CSR_NUM_W-1:0] csr_num;
    } mem_wb_bundle_t;

    // Exception bundle from MEM: {exc[14:0], badv[31:0]}
    typedef struct packed {
        logic [EXC_W-1:0] exc;
        logic [XLEN-1:0]  badv;
    } exc_bundle_t;

    // Exception vector bit positions, highest index wins
    localparam int unsigned EXC_INT    = 14;
    localparam int unsigned EXC_ADEF   = 13;
    localparam int unsigned EXC_TLBR_F = 12;
    localparam int unsigned EXC_PIF    = 11;
    localparam int unsigned EXC_PPI_F  = 10;
    localparam int unsigned EXC_INE    = 9;
    localparam int unsigned EXC_SYS    = 8;
    localparam int unsigned EXC_BRK    = 7;
    localparam int unsigned EXC_ALE    = 6;
    localparam int unsigned EXC_TLBR_M = 5;
    localparam int unsigned EXC_PIL    = 4;
    localparam int unsigned EXC_PIS    = 3;
    localparam int unsigned EXC_PME    = 2;
    localparam int unsigned EXC_PPI_M  = 1;
    localparam int unsigned EXC_ERTN   = 0;

    // Architectural exception codes
    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_PIL  = 6'h01;
    localparam logic [ECODE_W-1:0] ECODE_PIS  = 6'h02;
    localparam logic [ECODE_W-1:0] ECODE_PIF  = 6'h03;
    localparam logic [ECODE_W-1:0] ECODE_PME  = 6'h04;
    localparam logic [ECODE_W-1:0] ECODE_PPI  = 6'h07;
    localparam logic [ECODE_W-1:0] ECODE_ADE  = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
    localparam logic [ECODE_W-1:0] ECODE_TLBR = 6'h3F;

    localparam logic [ESUB_W-1:0] ESUB_NONE = 9'h000;
    localparam logic [ESUB_W-1:0] ESUB_ADEF = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_TLB_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } wb_state_e;

    // TLB request vector {rd,wr,fill,inv} carried by a bundle
    function automatic logic [TLB_OP_W-1:0] tlb_op_of(input mem_wb_bundle_t b);
        return {b.tlbrd, b.tlbwr, b.tlbfill, b.invtlb};
    endfunction

endpackage

// File: rtl/wb_exc_encoder.sv
// Priority encoder for the committed exception vector: picks the highest set
// bit and reports its code, whether BADV is written and where it comes from.
module wb_exc_encoder
    import wb_commit_stage_pkg::*;
(
    input  logic [EXC_W-1:0]   exc,
    output logic               has_exc,
    output logic               is_ertn,
    output logic [ECODE_W-1:0] ecode,
    output logic [ESUB_W-1:0]  esubcode,
    output logic               badv_valid,
    output logic               badv_sel_pc,
    output logic               to_tlbr
);

    // Highest-priority exception decode; ERTN only retires when nothing above it is set
    always_comb begin
        has_exc     = |exc[EXC_W-1:1];
        is_ertn     = exc[EXC_ERTN] & ~has_exc;
        ecode       = ECODE_INT;
        esubcode    = ESUB_NONE;
        badv_valid  = 1'b0;
        badv_sel_pc = 1'b0;
        to_tlbr     = 1'b0;
        if (exc[EXC_INT]) begin
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF]) begin
            ecode       = ECODE_ADE;
            esubcode    = ESUB_ADEF;
            badv_valid  = 1'b1;
            badv_sel_pc = 1'b1;
        end else if (exc[EXC_TLBR_F]) begin
            ecode       = ECODE_TLBR;
            badv_valid  = 1'b1;
            badv_sel_pc = 1'b1;
            to_tlbr     = 1'b1;
        end else if (exc[EXC_PIF]) begin
            ecode       = ECODE_PIF;
            badv_valid  = 1'b1;
            badv_sel_pc = 1'b1;
        end else if (exc[EXC_PPI_F]) begin
            ecode       = ECODE_PPI;
            badv_valid  = 1'b1;
            badv_sel_pc = 1'b1;
        end else if (exc[EXC_INE]) begin
            ecode = ECODE_INE;
        end else if (exc[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc[EXC_ALE]) begin
            ecode      = ECODE_ALE;
            badv_valid = 1'b1;
        end else if (exc[EXC_TLBR_M]) begin
            ecode      = ECODE_TLBR;
            badv_valid = 1'b1;
            to_tlbr    = 1'b1;
        end else if (exc[EXC_PIL]) begin
            ecode      = ECODE_PIL;
            badv_valid = 1'b1;
        end else if (exc[EXC_PIS]) begin
            ecode      = ECODE_PIS;
            badv_valid = 1'b1;
        end else if (exc[EXC_PME]) begin
            ecode      = ECODE_PME;
            badv_valid = 1'b1;
        end else if (exc[EXC_PPI_M]) begin
            ecode      = ECODE_PPI;
            badv_valid = 1'b1;
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Final pipeline stage: latches the MEM->WB and exception bundles, then commits
// GPR/CSR writes, reports exceptions and ERTN, issues TLB ops and raises the
// pipeline flush with its redirect target.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    output logic                 WB_allowin,
    input  logic                 MEM_to_WB,
    input  logic [ZIP_W-1:0]     MEM_to_WB_zip,
    input  logic [EXC_BUS_W-1:0] MEM_except_zip,

    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,

    output logic                 front_valid,
    output logic [REG_AW-1:0]    front_addr,
    output logic [XLEN-1:0]      front_data,

    output logic                 WB_is_csr,
    output logic                 csr_re,
    output logic                 csr_we,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic [XLEN-1:0]      csr_wmask,
    output logic [XLEN-1:0]      csr_wvalue,
    input  logic [XLEN-1:0]      csr_rvalue,

    output logic                 ex_commit,
    output logic [ECODE_W-1:0]   ex_ecode,
    output logic [ESUB_W-1:0]    ex_esubcode,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_badv,
    output logic                 ex_badv_valid,
    output logic                 ertn_commit,

    output logic [TLB_OP_W-1:0]  tlb_op,
    input  logic                 tlb_ack,

    input  logic [XLEN-1:0]      ex_entry,
    input  logic [XLEN-1:0]      tlbr_entry,
    input  logic [XLEN-1:0]      era,

    output logic                 flush,
    output logic [XLEN-1:0]      flush_target,

    output logic [XLEN-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [REG_AW-1:0]    debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata
);

    wb_state_e            state_q, state_d;
    mem_wb_bundle_t       bundle_q, bundle_d;
    exc_bundle_t          exc_q, exc_d;
    logic [TLB_OP_W-1:0]  tlb_op_q, tlb_op_d;
    logic                 flush_q, flush_d;
    logic [XLEN-1:0]      flush_target_q, flush_target_d;

    mem_wb_bundle_t       zip_in;
    exc_bundle_t          exc_in;

    logic                 enc_has_exc;
    logic                 enc_is_ertn;
    logic [ECODE_W-1:0]   enc_ecode;
    logic [ESUB_W-1:0]    enc_esubcode;
    logic                 enc_badv_valid;
    logic                 enc_badv_sel_pc;
    logic                 enc_to_tlbr;

    logic                 in_commit;
    logic                 ins_valid;
    logic                 any_exc;
    logic                 ins_exc;
    logic                 ins_ertn;
    logic                 ins_tlb;
    logic                 redirect;
    logic                 accept;
    logic                 unused_ir;

    assign zip_in = mem_wb_bundle_t'(MEM_to_WB_zip);
    assign exc_in = exc_bundle_t'(MEM_except_zip);

    wb_exc_encoder u_exc_encoder (
        .exc         (exc_q.exc),
        .has_exc     (enc_has_exc),
        .is_ertn     (enc_is_ertn),
        .ecode       (enc_ecode),
        .esubcode    (enc_esubcode),
        .badv_valid  (enc_badv_valid),
        .badv_sel_pc (enc_badv_sel_pc),
        .to_tlbr     (enc_to_tlbr)
    );

    // Commit-cycle qualifiers; any nonzero exc (ERTN included) blocks side effects
    always_comb begin
        in_commit = (state_q == ST_COMMIT);
        ins_valid = in_commit & bundle_q.valid;
        any_exc   = |exc_q.exc;
        ins_exc   = ins_valid & enc_has_exc;
        ins_ertn  = ins_valid & enc_is_ertn;
        ins_tlb   = ins_valid & ~any_exc & (|tlb_op_of(bundle_q));
        redirect  = ins_exc | ins_ertn;
        WB_allowin = (state_q == ST_IDLE) | (in_commit & ~redirect & ~ins_tlb);
        // In FLUSH the bundle is taken but squashed so upstream is never stuck
        accept    = MEM_to_WB & (WB_allowin | (state_q == ST_FLUSH));
    end

    // Next-state, bundle capture, TLB hold and flush/redirect generation
    always_comb begin
        state_d        = state_q;
        bundle_d       = bundle_q;
        exc_d          = exc_q;
        tlb_op_d       = tlb_op_q;
        flush_d        = 1'b0;
        flush_target_d = flush_target_q;

        if (accept) begin
            bundle_d       = zip_in;
            bundle_d.valid = zip_in.valid & ~flush_q;
            exc_d          = exc_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (MEM_to_WB) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (redirect) begin
                    state_d        = ST_FLUSH;
                    flush_d        = 1'b1;
                    flush_target_d = ins_ertn    ? era
                                   : enc_to_tlbr ? tlbr_entry
                                   :               ex_entry;
                end else if (ins_tlb) begin
                    state_d  = ST_TLB_WAIT;
                    tlb_op_d = tlb_op_of(bundle_q);
                end else if (MEM_to_WB) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TLB_WAIT: begin
                if (tlb_ack) begin
                    state_d        = ST_FLUSH;
                    tlb_op_d       = '0;
                    flush_d        = 1'b1;
                    flush_target_d = XLEN'(bundle_q.pc + XLEN'(4));
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bundle registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bundle_q       <= '0;
            exc_q          <= '0;
            tlb_op_q       <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
        end else begin
            state_q        <= state_d;
            bundle_q       <= bundle_d;
            exc_q          <= exc_d;
            tlb_op_q       <= tlb_op_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
        end
    end

    // Commit-side outputs decoded from the held bundle in the COMMIT cycle
    always_comb begin
        rf_we       = ins_valid & bundle_q.gr_we & ~any_exc;
        rf_waddr    = bundle_q.rf_waddr;
        rf_wdata    = bundle_q.csr_re ? csr_rvalue : bundle_q.rf_wdata;

        front_valid = ins_valid & bundle_q.gr_we;
        front_addr  = rf_waddr;
        front_data  = rf_wdata;

        WB_is_csr   = ins_valid & (bundle_q.csr_re | bundle_q.csr_we);
        csr_re      = ins_valid & bundle_q.csr_re & ~any_exc;
        csr_we      = ins_valid & bundle_q.csr_we & ~any_exc;
        csr_num     = bundle_q.csr_num;
        csr_wmask   = bundle_q.csr_wmask;
        csr_wvalue  = bundle_q.csr_wvalue;

        ex_commit     = ins_exc;
        ex_ecode      = ins_exc ? enc_ecode    : '0;
        ex_esubcode   = ins_exc ? enc_esubcode : '0;
        ex_pc         = bundle_q.pc;
        ex_badv_valid = ins_exc & enc_badv_valid;
        ex_badv       = enc_badv_sel_pc ? bundle_q.pc : exc_q.badv;
        ertn_commit   = ins_ertn;

        tlb_op        = tlb_op_q;
        flush         = flush_q;
        flush_target  = flush_target_q;

        debug_wb_pc       = ins_valid ? bundle_q.pc : '0;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

    // Instruction word travels in the bundle for trace tools only
    assign unused_ir = ^bundle_q.ir;

endmodule

// File: tb/tb_wb_commit_stage.sv
module tb_wb_commit_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         WB_allowin;
    logic         MEM_to_WB;
    logic [186:0] MEM_to_WB_zip;
    logic [46:0]  MEM_except_zip;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         front_valid;
    logic [4:0]   front_addr;
    logic [31:0]  front_data;
    logic         WB_is_csr;
    logic         csr_re;
    logic         csr_we;
    logic [13:0]  csr_num;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic [31:0]  csr_rvalue;
    logic         ex_commit;
    logic [5:0]   ex_ecode;
    logic [8:0]   ex_esubcode;
    logic [31:0]  ex_pc;
    logic [31:0]  ex_badv;
    logic         ex_badv_valid;
    logic         ertn_commit;
    logic [3:0]   tlb_op;
    logic         tlb_ack;
    logic [31:0]  ex_entry;
    logic [31:0]  tlbr_entry;
    logic [31:0]  era;
    logic         flush;
    logic [31:0]  flush_target;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    localparam int B_INT    = 14;
    localparam int B_TLBR_F = 12;
    localparam int B_INE    = 9;
    localparam int B_SYS    = 8;
    localparam int B_ALE    = 6;
    localparam int B_ERTN   = 0;

    localparam logic [31:0] EX_ENTRY   = 32'h1c00_8000;
    localparam logic [31:0] TLBR_ENTRY = 32'h1c00_f000;
    localparam logic [31:0] ERA        = 32'h1c00_0300;

    typedef struct {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_re;
        logic        ex;
        logic [5:0]  ecode;
        logic        badv_valid;
        logic [31:0] badv;
        logic        ertn;
        logic        allowin;
    } exp_t;

    exp_t sb[$];
    logic sent = 1'b0;

    always #5 clk = ~clk;

    wb_commit_stage dut (
        .clk               (clk),
        .rst               (rst),
        .WB_allowin        (WB_allowin),
        .MEM_to_WB         (MEM_to_WB),
        .MEM_to_WB_zip     (MEM_to_WB_zip),
        .MEM_except_zip    (MEM_except_zip),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .front_valid       (front_valid),
        .front_addr        (front_addr),
        .front_data        (front_data),
        .WB_is_csr         (WB_is_csr),
        .csr_re            (csr_re),
        .csr_we            (csr_we),
        .csr_num           (csr_num),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .csr_rvalue        (csr_rvalue),
        .ex_commit         (ex_commit),
        .ex_ecode          (ex_ecode),
        .ex_esubcode       (ex_esubcode),
        .ex_pc             (ex_pc),
        .ex_badv           (ex_badv),
        .ex_badv_valid     (ex_badv_valid),
        .ertn_commit       (ertn_commit),
        .tlb_op            (tlb_op),
        .tlb_ack           (tlb_ack),
        .ex_entry          (ex_entry),
        .tlbr_entry        (tlbr_entry),
        .era               (era),
        .flush             (flush),
        .flush_target      (flush_target),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ebit(input int i);
        logic [14:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // {valid,pc,IR,gr_we,waddr,wdata,tlbrd,tlbwr,tlbfill,invtlb,csr_re,csr_we,wmask,wvalue,num}
    function automatic logic [186:0] mk_zip(input logic [31:0] pc, input logic gr_we,
                                            input logic [4:0] wa, input logic [31:0] wd,
                                            input logic [3:0] tlb, input logic cre,
                                            input logic cwe, input logic [13:0] num);
        return {1'b1, pc, 32'h0000_0013, gr_we, wa, wd, tlb, cre, cwe,
                32'hFFFF_FFFF, 32'h0000_0000, num};
    endfunction

    function automatic exp_t mk_exp(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                    input logic cre, input logic ex, input logic [5:0] ec,
                                    input logic bv, input logic [31:0] badv,
                                    input logic ertn, input logic allowin);
        exp_t e;
        e.rf_we = we; e.waddr = wa; e.wdata = wd; e.csr_re = cre;
        e.ex = ex; e.ecode = ec; e.badv_valid = bv; e.badv = badv;
        e.ertn = ertn; e.allowin = allowin;
        return e;
    endfunction

    task automatic send(input logic [186:0] z, input logic [14:0] exc,
                        input logic [31:0] badv, input exp_t e);
        MEM_to_WB      = 1'b1;
        MEM_to_WB_zip  = z;
        MEM_except_zip = {exc, badv};
        sb.push_back(e);
        sent = 1'b1;
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("rf_we", 32'(rf_we), 32'(e.rf_we));
        chk("debug_wb_rf_we", 32'(debug_wb_rf_we), 32'({4{e.rf_we}}));
        if (e.rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("rf_wdata", rf_wdata, e.wdata);
        end
        chk("csr_re", 32'(csr_re), 32'(e.csr_re));
        chk("ex_commit", 32'(ex_commit), 32'(e.ex));
        chk("ertn_commit", 32'(ertn_commit), 32'(e.ertn));
        chk("WB_allowin", 32'(WB_allowin), 32'(e.allowin));
        if (e.ex) begin
            chk("ex_ecode", 32'(ex_ecode), 32'(e.ecode));
            chk("ex_badv_valid", 32'(ex_badv_valid), 32'(e.badv_valid));
            if (e.badv_valid) chk("ex_badv", ex_badv, e.badv);
        end
    endtask

    // Advance one clock, sample #1 after the edge, score anything sent last cycle
    task automatic tick();
        @(posedge clk);
        #1;
        MEM_to_WB = 1'b0;
        if (sent) begin
            sent = 1'b0;
            compare_head();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        MEM_to_WB      = 1'b0;
        MEM_to_WB_zip  = '0;
        MEM_except_zip = '0;
        csr_rvalue     = '0;
        tlb_ack        = 1'b0;
        ex_entry       = EX_ENTRY;
        tlbr_entry     = TLBR_ENTRY;
        era            = ERA;

        // Reset state
        tick(); tick();
        chk("rst_allowin", 32'(WB_allowin), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_tlb_op", 32'(tlb_op), 32'd0);
        chk("rst_flush_target", flush_target, 32'd0);
        chk("rst_debug_pc", debug_wb_pc, 32'd0);
        rst = 1'b0;
        tick();

        // add.w r4 <- 0x1234
        send(mk_zip(32'h1c00_0000, 1'b1, 5'd4, 32'h0000_1234, 4'b0000, 1'b0, 1'b0, 14'h0),
             15'h0, 32'h0, mk_exp(1, 5'd4, 32'h0000_1234, 0, 0, 6'h0, 0, 32'h0, 0, 1));
        tick();
        chk("add_flush", 32'(flush), 32'd0);
        chk("add_front_valid", 32'(front_valid), 32'd1);
        chk("add_front_data", front_data, 32'h0000_1234);
        chk("add_debug_pc", debug_wb_pc, 32'h1c00_0000);
        tick();
        chk("add_idle_rf_we", 32'(rf_we), 32'd0);

        // csrrd num 0x5 -> r6 gets csr_rvalue
        csr_rvalue = 32'h0000_00A5;
        send(mk_zip(32'h1c00_0004, 1'b1, 5'd6, 32'h0000_DEAD, 4'b0000, 1'b1, 1'b0, 14'h5),
             15'h0, 32'h0, mk_exp(1, 5'd6, 32'h0000_00A5, 1, 0, 6'h0, 0, 32'h0, 0, 1));
        tick();
        chk("csr_num", 32'(csr_num), 32'h5);
        chk("csr_is_csr", 32'(WB_is_csr), 32'd1);
        tick();
        chk("csr_re_one_cycle", 32'(csr_re), 32'd0);

        // SYS at 0x1c000100
        send(mk_zip(32'h1c00_0100, 1'b1, 5'd7, 32'h0000_0055, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_SYS), 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h0B, 0, 32'h0, 0, 0));
        tick();
        chk("sys_ex_pc", ex_pc, 32'h1c00_0100);
        chk("sys_flush_not_yet", 32'(flush), 32'd0);
        tick();
        chk("sys_flush", 32'(flush), 32'd1);
        chk("sys_target", flush_target, EX_ENTRY);
        chk("sys_flush_allowin", 32'(WB_allowin), 32'd0);
        tick();
        chk("sys_flush_pulse", 32'(flush), 32'd0);
        chk("sys_idle_allowin", 32'(WB_allowin), 32'd1);

        // ALE with bad address 0x1003
        send(mk_zip(32'h1c00_0110, 1'b1, 5'd8, 32'h0, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_ALE), 32'h0000_1003, mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h09, 1, 32'h0000_1003, 0, 0));
        tick(); tick();
        chk("ale_target", flush_target, EX_ENTRY);
        tick();

        // INT and ALE together: INT wins, no BADV
        send(mk_zip(32'h1c00_0120, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_INT) | ebit(B_ALE), 32'h0000_2000,
             mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h00, 0, 32'h0, 0, 0));
        tick(); tick();
        chk("int_target", flush_target, EX_ENTRY);
        tick();

        // TLB refill on fetch: BADV from pc, redirect to refill entry
        send(mk_zip(32'h1c00_0400, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_TLBR_F), 32'h0000_9999,
             mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h3F, 1, 32'h1c00_0400, 0, 0));
        tick(); tick();
        chk("tlbr_flush", 32'(flush), 32'd1);
        chk("tlbr_target", flush_target, TLBR_ENTRY);
        tick();

        // tlbwr with ack in the third wait cycle
        send(mk_zip(32'h1c00_0200, 1'b0, 5'd0, 32'h0, 4'b0100, 1'b0, 1'b0, 14'h0),
             15'h0, 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 0, 6'h0, 0, 32'h0, 0, 0));
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("tlbwr_op_c%0d", i), 32'(tlb_op), 32'b0100);
            chk($sformatf("tlbwr_allowin_c%0d", i), 32'(WB_allowin), 32'd0);
            chk($sformatf("tlbwr_flush_c%0d", i), 32'(flush), 32'd0);
            if (i == 2) tlb_ack = 1'b1;
        end
        tick();
        tlb_ack = 1'b0;
        chk("tlbwr_flush", 32'(flush), 32'd1);
        chk("tlbwr_target", flush_target, 32'h1c00_0204);
        chk("tlbwr_op_released", 32'(tlb_op), 32'd0);
        tick();
        chk("tlbwr_idle_allowin", 32'(WB_allowin), 32'd1);

        // Reset while waiting on the TLB, then a stale ack
        send(mk_zip(32'h1c00_0500, 1'b0, 5'd0, 32'h0, 4'b1000, 1'b0, 1'b0, 14'h0),
             15'h0, 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 0, 6'h0, 0, 32'h0, 0, 0));
        tick(); tick();
        chk("tlbrd_op", 32'(tlb_op), 32'b1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwait_tlb_op", 32'(tlb_op), 32'd0);
        chk("rstwait_allowin", 32'(WB_allowin), 32'd1);
        tlb_ack = 1'b1;
        tick();
        tlb_ack = 1'b0;
        tick();
        chk("late_ack_flush", 32'(flush), 32'd0);
        chk("late_ack_allowin", 32'(WB_allowin), 32'd1);

        // ERTN redirects to ERA
        send(mk_zip(32'h1c00_0600, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_ERTN), 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 0, 6'h0, 0, 32'h0, 1, 0));
        tick(); tick();
        chk("ertn_flush", 32'(flush), 32'd1);
        chk("ertn_target", flush_target, ERA);
        tick();

        // INE on an instruction carrying csr_we and a TLB op: all side effects blocked
        send(mk_zip(32'h1c00_0700, 1'b1, 5'd9, 32'h77, 4'b0100, 1'b0, 1'b1, 14'h6),
             ebit(B_INE), 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h0D, 0, 32'h0, 0, 0));
        tick();
        chk("ine_csr_we", 32'(csr_we), 32'd0);
        tick();
        chk("ine_target", flush_target, EX_ENTRY);
        chk("ine_tlb_op", 32'(tlb_op), 32'd0);
        tick();

        // Back-to-back plain commits
        send(mk_zip(32'h1c00_0800, 1'b1, 5'd10, 32'h1111_1111, 4'b0000, 1'b0, 1'b0, 14'h0),
             15'h0, 32'h0, mk_exp(1, 5'd10, 32'h1111_1111, 0, 0, 6'h0, 0, 32'h0, 0, 1));
        tick();
        send(mk_zip(32'h1c00_0804, 1'b1, 5'd11, 32'h2222_2222, 4'b0000, 1'b0, 1'b0, 14'h0),
             15'h0, 32'h0, mk_exp(1, 5'd11, 32'h2222_2222, 0, 0, 6'h0, 0, 32'h0, 0, 1));
        tick();
        chk("b2b_debug_pc", debug_wb_pc, 32'h1c00_0804);
        tick();
        chk("b2b_idle_rf_we", 32'(rf_we), 32'd0);

        // A bundle offered during FLUSH is squashed
        send(mk_zip(32'h1c00_0900, 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 14'h0),
             ebit(B_SYS), 32'h0, mk_exp(0, 5'd0, 32'h0, 0, 1, 6'h0B, 0, 32'h0, 0, 0));
        tick(); tick();
        chk("drop_flush", 32'(flush), 32'd1);
        MEM_to_WB      = 1'b1;
        MEM_to_WB_zip  = mk_zip(32'h1c00_0a00, 1'b1, 5'd12, 32'h3333_3333, 4'b0000, 1'b0, 1'b0, 14'h0);
        MEM_except_zip = '0;
        tick();
        chk("drop_rf_we", 32'(rf_we), 32'd0);
        chk("drop_debug_pc", debug_wb_pc, 32'd0);
        tick();
        chk("drop_rf_we_later", 32'(rf_we), 32'd0);
        chk("drop_allowin", 32'(WB_allowin), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
